px_serializer: RTL and testbench

PX_SERIALIZER -- requirements
Module: px_serializer

---
 rtl/px_serializer_pkg.sv | 18 +
 rtl/px_frame_reg.sv | 59 +++++
 rtl/px_serializer.sv | 119 +++++++++++
 tb/tb_px_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/px_serializer_pkg.sv
// Shared definitions for the background-remover pixel path: pixel width,
// serializer state encoding and the pixel-index width derivation.
package px_serializer_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } px_state_e;

  // Index width for a frame of n pixels; never narrower than one bit.
  function automatic int px_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/px_frame_reg.sv
// Captured frame store: snapshots the three colour buses and the background
// colour on capture, then presents one selected pixel and whether it matches
// the background.
module px_frame_reg
  import px_serializer_pkg::*;
#(
  parameter  int NUM_PIXELS = 4,
  localparam int IDX_W      = px_idx_w(NUM_PIXELS)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        capture,
  input  logic [PIX_W*NUM_PIXELS-1:0] red_in,
  input  logic [PIX_W*NUM_PIXELS-1:0] green_in,
  input  logic [PIX_W*NUM_PIXELS-1:0] blue_in,
  input  logic [PIX_W-1:0]            bg_r,
  input  logic [PIX_W-1:0]            bg_g,
  input  logic [PIX_W-1:0]            bg_b,
  input  logic [IDX_W-1:0]            sel,
  output logic [PIX_W-1:0]            pix_r,
  output logic [PIX_W-1:0]            pix_g,
  output logic [PIX_W-1:0]            pix_b,
  output logic                        is_bg
);

  logic [PIX_W-1:0] r_q [NUM_PIXELS];
  logic [PIX_W-1:0] g_q [NUM_PIXELS];
  logic [PIX_W-1:0] b_q [NUM_PIXELS];
  logic [PIX_W-1:0] bgr_q, bgg_q, bgb_q;

  // Snapshot the whole frame and background colour; later bus changes are ignored.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        r_q[i] <= '0;
        g_q[i] <= '0;
        b_q[i] <= '0;
      end
      bgr_q <= '0;
      bgg_q <= '0;
      bgb_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        r_q[i] <= red_in[PIX_W*i +: PIX_W];
        g_q[i] <= green_in[PIX_W*i +: PIX_W];
        b_q[i] <= blue_in[PIX_W*i +: PIX_W];
      end
      bgr_q <= bg_r;
      bgg_q <= bg_g;
      bgb_q <= bg_b;
    end
  end

  assign pix_r = r_q[sel];
  assign pix_g = g_q[sel];
  assign pix_b = b_q[sel];
  assign is_bg = (pix_r == bgr_q) && (pix_g == bgg_q) && (pix_b == bgb_q);

endmodule

// File: rtl/px_serializer.sv
// Frame serializer: captures a processed frame on Start, streams it one pixel
// per valid/ready handshake, counts background-coloured pixels, and parks in
// DONE until acknowledged.
module px_serializer
  import px_serializer_pkg::*;
#(
  parameter  int NUM_PIXELS = 4,
  localparam int IDX_W      = px_idx_w(NUM_PIXELS)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [PIX_W*NUM_PIXELS-1:0] red_in,
  input  logic [PIX_W*NUM_PIXELS-1:0] green_in,
  input  logic [PIX_W*NUM_PIXELS-1:0] blue_in,
  input  logic [PIX_W-1:0]            bg_r,
  input  logic [PIX_W-1:0]            bg_g,
  input  logic [PIX_W-1:0]            bg_b,
  input  logic                        Out_Ready,
  input  logic                        Ack,
  output logic                        Out_Valid,
  output logic [PIX_W-1:0]            Out_Red,
  output logic [PIX_W-1:0]            Out_Green,
  output logic [PIX_W-1:0]            Out_Blue,
  output logic [IDX_W-1:0]            Out_Idx,
  output logic                        Out_Last,
  output logic [IDX_W:0]              Bg_Count,
  output logic                        Qi,
  output logic                        Qs,
  output logic                        Qd
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

  px_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   cnt_q;
  logic             capture, xfer, is_last;
  logic             is_bg;
  logic [PIX_W-1:0] pix_r, pix_g, pix_b;

  px_frame_reg #(.NUM_PIXELS(NUM_PIXELS)) u_frame (
    .Clk      (Clk),
    .Reset    (Reset),
    .capture  (capture),
    .red_in   (red_in),
    .green_in (green_in),
    .blue_in  (blue_in),
    .bg_r     (bg_r),
    .bg_g     (bg_g),
    .bg_b     (bg_b),
    .sel      (ptr_q),
    .pix_r    (pix_r),
    .pix_g    (pix_g),
    .pix_b    (pix_b),
    .is_bg    (is_bg)
  );

  assign is_last = (ptr_q == LAST_IDX);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus capture/transfer strobes; Start only counts in IDLE, Ack only in DONE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          capture = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Out_Ready) begin
          xfer = 1'b1;
          if (is_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer and background counter; the pointer stops on the last pixel instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (capture) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (xfer) begin
      if (!is_last) ptr_q <= ptr_q + PTR_ONE;
      if (is_bg)    cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign Qi        = (state_q == ST_IDLE);
  assign Qs        = (state_q == ST_SEND);
  assign Qd        = (state_q == ST_DONE);
  assign Out_Valid = Qs;
  assign Out_Red   = Qs ? pix_r : '0;
  assign Out_Green = Qs ? pix_g : '0;
  assign Out_Blue  = Qs ? pix_b : '0;
  assign Out_Idx   = Qs ? ptr_q : '0;
  assign Out_Last  = Qs && is_last;
  assign Bg_Count  = cnt_q;

endmodule

// File: tb/tb_px_serializer.sv
// Bench for px_serializer: directed and randomized frames checked against a
// frame-level model (list of pixels, count of background matches).
module tb_px_serializer;

  localparam int N  = 4;
  localparam int IW = (N <= 1) ? 1 : $clog2(N);

  logic           Clk = 1'b0;
  logic           Reset, Start, Out_Ready, Ack;
  logic [8*N-1:0] red_in, green_in, blue_in;
  logic [7:0]     bg_r, bg_g, bg_b;
  logic           Out_Valid, Out_Last, Qi, Qs, Qd;
  logic [7:0]     Out_Red, Out_Green, Out_Blue;
  logic [IW-1:0]  Out_Idx;
  logic [IW:0]    Bg_Count;

  px_serializer #(.NUM_PIXELS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .Out_Ready(Out_Ready), .Ack(Ack),
    .Out_Valid(Out_Valid), .Out_Red(Out_Red), .Out_Green(Out_Green),
    .Out_Blue(Out_Blue), .Out_Idx(Out_Idx), .Out_Last(Out_Last),
    .Bg_Count(Bg_Count), .Qi(Qi), .Qs(Qs), .Qd(Qd)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model of the frame the DUT is expected to have captured.
  logic [7:0] mr [N];
  logic [7:0] mg [N];
  logic [7:0] mb [N];
  logic [7:0] mbr, mbg, mbb;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_count(input int upto);
    int c = 0;
    for (int i = 0; i < upto; i++)
      if (mr[i] == mbr && mg[i] == mbg && mb[i] == mbb) c++;
    return c;
  endfunction

  task automatic load_buses();
    for (int i = 0; i < N; i++) begin
      red_in[8*i +: 8]   = mr[i];
      green_in[8*i +: 8] = mg[i];
      blue_in[8*i +: 8]  = mb[i];
    end
    bg_r = mbr; bg_g = mbg; bg_b = mbb;
  endtask

  task automatic scramble_buses();
    for (int i = 0; i < N; i++) begin
      red_in[8*i +: 8]   = 8'($urandom);
      green_in[8*i +: 8] = 8'($urandom);
      blue_in[8*i +: 8]  = 8'($urandom);
    end
    bg_r = 8'($urandom); bg_g = 8'($urandom); bg_b = 8'($urandom);
  endtask

  task automatic directed_frame();
    mbr = 8'd106; mbg = 8'd168; mbb = 8'd79;
    mr[0] = 8'd204; mg[0] = 8'd0; mb[0] = 8'd0;
    for (int i = 1; i < N; i++) begin
      mr[i] = 8'd106; mg[i] = 8'd168; mb[i] = 8'd79;
    end
  endtask

  task automatic random_frame();
    mbr = 8'($urandom); mbg = 8'($urandom); mbb = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        mr[i] = mbr; mg[i] = mbg; mb[i] = mbb;
      end else begin
        mr[i] = 8'($urandom); mg[i] = 8'($urandom); mb[i] = 8'($urandom);
      end
    end
  endtask

  // mode: 0 = ready always, 1 = ready pattern 1,0,0,1 repeating, 2 = random ready.
  task automatic run_frame(input int mode, input bit repulse, input bit change_bus,
                           input bit ack_with_start, input bit chk_latency);
    int k   = 0;
    int cyc = 0;
    int ph  = 0;
    bit rdy;
    load_buses();
    Start = 1'b1;
    Ack   = ack_with_start;
    tick();
    Start = 1'b0;
    Ack   = 1'b0;
    cyc   = 1;
    if (change_bus) scramble_buses();
    while (k < N && cyc < 200) begin
      chk("send_valid", 32'(Out_Valid), 32'd1);
      chk("send_qs", 32'(Qs), 32'd1);
      chk("send_idx", 32'(Out_Idx), 32'(k));
      chk("send_red", 32'(Out_Red), 32'(mr[k]));
      chk("send_green", 32'(Out_Green), 32'(mg[k]));
      chk("send_blue", 32'(Out_Blue), 32'(mb[k]));
      chk("send_last", 32'(Out_Last), (k == N - 1) ? 32'd1 : 32'd0);
      chk("send_bgcount", 32'(Bg_Count), 32'(exp_count(k)));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
        default: rdy = ($urandom_range(1, 0) == 1);
      endcase
      ph++;
      Out_Ready = rdy;
      Start     = repulse && ($urandom_range(1, 0) == 1);
      if (Start) scramble_buses();
      Ack       = ($urandom_range(1, 0) == 1);
      tick();
      cyc++;
      if (rdy) k++;
    end
    Start = 1'b0; Ack = 1'b0; Out_Ready = 1'b0;
    chk("frame_transfers", 32'(k), 32'(N));
    chk("done_qd", 32'(Qd), 32'd1);
    chk("done_valid", 32'(Out_Valid), 32'd0);
    chk("done_last", 32'(Out_Last), 32'd0);
    chk("done_bgcount", 32'(Bg_Count), 32'(exp_count(N)));
    if (chk_latency) chk("done_latency", 32'(cyc), 32'(N + 1));
    // DONE must hold without Ack, even with Ready high.
    Out_Ready = 1'b1;
    tick();
    tick();
    Out_Ready = 1'b0;
    chk("done_hold_qd", 32'(Qd), 32'd1);
    chk("done_hold_bgcount", 32'(Bg_Count), 32'(exp_count(N)));
  endtask

  task automatic ack_to_idle();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk("ack_qi", 32'(Qi), 32'd1);
    chk("ack_qd", 32'(Qd), 32'd0);
    chk("ack_valid", 32'(Out_Valid), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Out_Ready = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0;
    bg_r = '0; bg_g = '0; bg_b = '0;

    // Reset held for five cycles.
    repeat (5) tick();
    chk("rst_qi", 32'(Qi), 32'd1);
    chk("rst_qs", 32'(Qs), 32'd0);
    chk("rst_qd", 32'(Qd), 32'd0);
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_bgcount", 32'(Bg_Count), 32'd0);
    Reset = 1'b0;
    tick();
    chk("idle_stays", 32'(Qi), 32'd1);

    // Reference frame, ready always high, with latency check.
    directed_frame();
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack_to_idle();

    // Same frame with a stalling consumer.
    directed_frame();
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0);
    ack_to_idle();

    // Start re-pulsed (with changed buses) during SEND must be ignored.
    random_frame();
    run_frame(2, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_to_idle();

    // Buses change right after capture.
    random_frame();
    run_frame(2, 1'b0, 1'b1, 1'b0, 1'b0);
    ack_to_idle();

    // Start and Ack together in IDLE: Start wins.
    random_frame();
    run_frame(0, 1'b0, 1'b0, 1'b1, 1'b1);
    ack_to_idle();

    // Asynchronous reset after the second transfer.
    directed_frame();
    load_buses();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Out_Ready = 1'b1;
    tick();
    tick();
    chk("pre_abort_idx", 32'(Out_Idx), 32'd2);
    chk("pre_abort_bgcount", 32'(Bg_Count), 32'(exp_count(2)));
    #2 Reset = 1'b1;
    #1;
    chk("abort_qi", 32'(Qi), 32'd1);
    chk("abort_qs", 32'(Qs), 32'd0);
    chk("abort_valid", 32'(Out_Valid), 32'd0);
    chk("abort_bgcount", 32'(Bg_Count), 32'd0);
    chk("abort_red", 32'(Out_Red), 32'd0);
    chk("abort_idx", 32'(Out_Idx), 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    chk("abort_no_xfer_qi", 32'(Qi), 32'd1);
    chk("abort_no_xfer_valid", 32'(Out_Valid), 32'd0);
    Out_Ready = 1'b0;
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack_to_idle();

    // Randomized frames with random flow control, re-pulses and bus changes.
    for (int f = 0; f < 20; f++) begin
      random_frame();
      run_frame(2, ($urandom_range(1, 0) == 1), ($urandom_range(1, 0) == 1),
                ($urandom_range(1, 0) == 1), 1'b0);
      ack_to_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
